rsi_scale_zone: RTL and testbench

- Downstream neighbour of the RS stage. Consumes the uq8_8 relative strength and its one-cycle valid pulse.
- Computes RSI = 100 − 100/(1+RS) as uq8_8 in the range 0.0..100.0, using a multi-cycle restoring divider.
- Classifies each result into an overbought, oversold or neutral zone and pulses buy/sell crossing events for the strategy/reporting logic.
- Upstream has no backpressure, so the block holds one pending sample and flags overruns.

---
 rtl/fixed_pkg.sv | 33 +++
 rtl/rsi_div_restoring.sv | 55 +++++
 rtl/rsi_scale_zone.sv | 145 ++++++++++++++
 tb/tb_rsi_scale_zone.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fixed_pkg.sv
// Shared fixed-point types, constants and zone helpers for the RSI scaling stage.
package fixed_pkg;

  typedef logic [15:0] uq8_8_t;

  localparam uq8_8_t      RSI_FULL_SCALE = 16'd25600;   // 100.0 in uq8_8
  localparam logic [22:0] RSI_NUM        = 23'd6553600; // 100 * 2^16
  localparam logic [4:0]  DIV_LAST_BIT   = 5'd22;       // numerator MSB index

  typedef enum logic [1:0] {
    ZONE_NEUTRAL    = 2'b00,
    ZONE_OVERSOLD   = 2'b01,
    ZONE_OVERBOUGHT = 2'b10
  } rsi_zone_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DIV  = 2'b01,
    ST_OUT  = 2'b10
  } rsi_state_t;

  // 1 + RS in Q9.8
  function automatic logic [16:0] rs_to_den(input uq8_8_t rs);
    return 17'(rs) + 17'd256;
  endfunction

  function automatic rsi_zone_t classify(input uq8_8_t rsi, input uq8_8_t ob, input uq8_8_t os);
    if (rsi >= ob)      return ZONE_OVERBOUGHT;
    else if (rsi <= os) return ZONE_OVERSOLD;
    else                return ZONE_NEUTRAL;
  endfunction

endpackage

// File: rtl/rsi_div_restoring.sv
// Sequential restoring divider: RSI_NUM / i_den, one quotient bit per cycle, MSB first.
module rsi_div_restoring
  import fixed_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [16:0] i_den,
  output logic [14:0] o_quot,
  output logic        o_last
);

  logic [16:0] den_q;
  logic [16:0] rem_q;
  logic [14:0] quot_q;
  logic [4:0]  cnt_q;
  logic        busy_q;

  logic [17:0] rem_sh;
  logic        ge;
  logic [16:0] rem_nx;

  // One trial subtraction on the remainder with the next numerator bit shifted in
  always_comb begin
    rem_sh = {rem_q, RSI_NUM[cnt_q]};
    ge     = (rem_sh >= {1'b0, den_q});
    rem_nx = ge ? 17'(rem_sh - {1'b0, den_q}) : rem_sh[16:0];
  end

  // Quotient fits in 15 bits, so bits shifted past the top are always zero
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      den_q  <= '0;
      rem_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (i_start) begin
      den_q  <= i_den;
      rem_q  <= '0;
      quot_q <= '0;
      cnt_q  <= DIV_LAST_BIT;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q  <= rem_nx;
      quot_q <= {quot_q[13:0], ge};
      if (cnt_q == 5'd0) busy_q <= 1'b0;
      else               cnt_q  <= cnt_q - 5'd1;
    end
  end

  assign o_quot = quot_q;
  assign o_last = busy_q && (cnt_q == 5'd0);

endmodule

// File: rtl/rsi_scale_zone.sv
// RSI = 100 - 100/(1+RS) with zone classification, crossing events and a one-deep pending slot.
module rsi_scale_zone
  import fixed_pkg::*;
#(
  parameter uq8_8_t OB_LEVEL = 16'd17920,
  parameter uq8_8_t OS_LEVEL = 16'd7680
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_rs,
  input  logic        i_rs_valid,
  output logic [15:0] o_rsi,
  output logic        o_rsi_valid,
  output logic [1:0]  o_zone,
  output logic        o_buy,
  output logic        o_sell,
  output logic        o_busy,
  output logic        o_overrun
);

  if (OS_LEVEL >= OB_LEVEL) begin : g_bad_levels
    $error("rsi_scale_zone: OS_LEVEL must be below OB_LEVEL");
  end

  rsi_state_t  state_q, state_nx;
  uq8_8_t      pend_q;
  logic        pend_full_q;
  rsi_zone_t   zone_q, zone_nx;

  logic        div_start;
  logic [16:0] div_den;
  logic [14:0] div_quot;
  logic        div_last;
  logic        pend_load, pend_clear, ovr_set;
  uq8_8_t      rsi_nx;

  rsi_div_restoring u_div (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (div_start),
    .i_den   (div_den),
    .o_quot  (div_quot),
    .o_last  (div_last)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_nx;
  end

  // Next state, divider launch and pending-slot control
  always_comb begin
    state_nx   = state_q;
    div_start  = 1'b0;
    div_den    = '0;
    pend_load  = 1'b0;
    pend_clear = 1'b0;
    ovr_set    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_rs_valid) begin
          div_start = 1'b1;
          div_den   = rs_to_den(i_rs);
          state_nx  = ST_DIV;
        end
      end
      ST_DIV: begin
        if (i_rs_valid) begin
          pend_load = 1'b1;
          ovr_set   = pend_full_q;
        end
        if (div_last) state_nx = ST_OUT;
      end
      ST_OUT: begin
        // Pending sample is consumed this edge, so a new arrival refills it without overrun
        if (pend_full_q) begin
          div_start = 1'b1;
          div_den   = rs_to_den(pend_q);
          state_nx  = ST_DIV;
          if (i_rs_valid) pend_load  = 1'b1;
          else            pend_clear = 1'b1;
        end else if (i_rs_valid) begin
          div_start = 1'b1;
          div_den   = rs_to_den(i_rs);
          state_nx  = ST_DIV;
        end else begin
          state_nx  = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Result value and its zone
  always_comb begin
    rsi_nx  = RSI_FULL_SCALE - {1'b0, div_quot};
    zone_nx = classify(rsi_nx, OB_LEVEL, OS_LEVEL);
  end

  // One-deep pending slot
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else if (pend_load) begin
      pend_q      <= i_rs;
      pend_full_q <= 1'b1;
    end else if (pend_clear) begin
      pend_full_q <= 1'b0;
    end
  end

  // Sticky overrun flag
  always_ff @(posedge i_clk) begin
    if (i_rst)        o_overrun <= 1'b0;
    else if (ovr_set) o_overrun <= 1'b1;
  end

  // Registered result, held zone and single-cycle crossing events
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rsi       <= '0;
      o_rsi_valid <= 1'b0;
      zone_q      <= ZONE_NEUTRAL;
      o_buy       <= 1'b0;
      o_sell      <= 1'b0;
    end else begin
      o_rsi_valid <= 1'b0;
      o_buy       <= 1'b0;
      o_sell      <= 1'b0;
      if (state_q == ST_OUT) begin
        o_rsi       <= rsi_nx;
        o_rsi_valid <= 1'b1;
        zone_q      <= zone_nx;
        o_buy       <= (zone_q == ZONE_OVERSOLD)   && (zone_nx != ZONE_OVERSOLD);
        o_sell      <= (zone_q == ZONE_OVERBOUGHT) && (zone_nx != ZONE_OVERBOUGHT);
      end
    end
  end

  assign o_zone = zone_q;
  assign o_busy = (state_q != ST_IDLE) || pend_full_q;

endmodule

// File: tb/tb_rsi_scale_zone.sv
// Directed self-checking bench for rsi_scale_zone.
module tb_rsi_scale_zone;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [15:0] i_rs = '0;
  logic        i_rs_valid = 1'b0;

  logic [15:0] o_rsi;
  logic        o_rsi_valid;
  logic [1:0]  o_zone;
  logic        o_buy, o_sell, o_busy, o_overrun;

  logic [15:0] b_rsi;
  logic        b_rsi_valid;
  logic [1:0]  b_zone;
  logic        b_buy, b_sell, b_busy, b_overrun;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rsi_scale_zone dut (
    .i_clk(clk), .i_rst(i_rst), .i_rs(i_rs), .i_rs_valid(i_rs_valid),
    .o_rsi(o_rsi), .o_rsi_valid(o_rsi_valid), .o_zone(o_zone),
    .o_buy(o_buy), .o_sell(o_sell), .o_busy(o_busy), .o_overrun(o_overrun)
  );

  // Thresholds set to reachable results so the inclusive comparisons are hit exactly
  rsi_scale_zone #(.OB_LEVEL(16'd17926), .OS_LEVEL(16'd7694)) dut_b (
    .i_clk(clk), .i_rst(i_rst), .i_rs(i_rs), .i_rs_valid(i_rs_valid),
    .o_rsi(b_rsi), .o_rsi_valid(b_rsi_valid), .o_zone(b_zone),
    .o_buy(b_buy), .o_sell(b_sell), .o_busy(b_busy), .o_overrun(b_overrun)
  );

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({o_rsi, o_rsi_valid, o_zone, o_buy, o_sell, o_busy, o_overrun} !== 23'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rsi=%0d v=%0b zone=%0b buy=%0b sell=%0b busy=%0b ovr=%0b, expected all 0",
               o_rsi, o_rsi_valid, o_zone, o_buy, o_sell, o_busy, o_overrun);
    end
    i_rst = 1'b0;
  endtask

  task automatic test_sample(input string name, input logic [15:0] rs, input logic [15:0] exp_rsi,
                             input logic [1:0] exp_zone, input logic exp_buy, input logic exp_sell,
                             input logic [1:0] exp_bzone);
    int cnt;
    @(negedge clk);
    i_rs = rs;
    i_rs_valid = 1'b1;
    @(posedge clk);
    #1;
    i_rs_valid = 1'b0;
    n_cmp++;
    if (o_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s busy: got %0b expected 1", name, o_busy);
    end
    cnt = 0;
    while (o_rsi_valid !== 1'b1 && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    n_cmp++;
    if (cnt !== 24) begin
      n_bad++;
      $display("FAIL %s latency: got %0d cycles expected 24", name, cnt);
    end
    n_cmp++;
    if (o_rsi !== exp_rsi) begin
      n_bad++;
      $display("FAIL %s rsi: got %0d expected %0d", name, o_rsi, exp_rsi);
    end
    n_cmp++;
    if (o_zone !== exp_zone) begin
      n_bad++;
      $display("FAIL %s zone: got %b expected %b", name, o_zone, exp_zone);
    end
    n_cmp++;
    if ({o_buy, o_sell} !== {exp_buy, exp_sell}) begin
      n_bad++;
      $display("FAIL %s events: got buy=%0b sell=%0b expected buy=%0b sell=%0b",
               name, o_buy, o_sell, exp_buy, exp_sell);
    end
    n_cmp++;
    if (b_zone !== exp_bzone) begin
      n_bad++;
      $display("FAIL %s zone_b: got %b expected %b", name, b_zone, exp_bzone);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({o_rsi_valid, o_buy, o_sell, o_busy} !== 4'b0000 || o_zone !== exp_zone) begin
      n_bad++;
      $display("FAIL %s pulse_end: got v=%0b buy=%0b sell=%0b busy=%0b zone=%b expected 0 0 0 0 %b",
               name, o_rsi_valid, o_buy, o_sell, o_busy, o_zone, exp_zone);
    end
  endtask

  task automatic test_overrun();
    int cnt;
    @(negedge clk);
    i_rs = 16'h0100;
    i_rs_valid = 1'b1;
    @(posedge clk);
    #1;
    i_rs = 16'h0300;
    @(posedge clk);
    #1;
    i_rs = 16'h0000;
    @(posedge clk);
    #1;
    i_rs_valid = 1'b0;
    n_cmp++;
    if (o_overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_set: got %0b expected 1", o_overrun);
    end
    cnt = 2;
    while (o_rsi_valid !== 1'b1 && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    n_cmp++;
    if (cnt !== 24 || o_rsi !== 16'd12800) begin
      n_bad++;
      $display("FAIL overrun_first: got %0d cycles rsi=%0d expected 24 cycles rsi=12800", cnt, o_rsi);
    end
    cnt = 0;
    @(posedge clk);
    #1;
    cnt++;
    while (o_rsi_valid !== 1'b1 && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    n_cmp++;
    if (cnt !== 24 || o_rsi !== 16'd0) begin
      n_bad++;
      $display("FAIL overrun_second: got %0d cycles rsi=%0d expected 24 cycles rsi=0 (sample C)", cnt, o_rsi);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (o_overrun !== 1'b1 || o_busy !== 1'b0 || o_rsi_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_sticky: got ovr=%0b busy=%0b v=%0b expected 1 0 0", o_overrun, o_busy, o_rsi_valid);
    end
  endtask

  task automatic test_reset_mid_div();
    int seen;
    @(negedge clk);
    i_rs = 16'h0080;
    i_rs_valid = 1'b1;
    @(posedge clk);
    #1;
    i_rs_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    n_cmp++;
    if ({o_rsi, o_rsi_valid, o_zone, o_buy, o_sell, o_busy, o_overrun} !== 23'd0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got rsi=%0d v=%0b zone=%0b buy=%0b sell=%0b busy=%0b ovr=%0b, expected all 0",
               o_rsi, o_rsi_valid, o_zone, o_buy, o_sell, o_busy, o_overrun);
    end
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (o_rsi_valid === 1'b1 || o_busy === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL midreset_quiet: got %0d active cycles expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_sample("rs_0",      16'h0000, 16'd0,     2'b01, 1'b0, 1'b0, 2'b01);
    test_sample("rs_1",      16'h0100, 16'd12800, 2'b00, 1'b1, 1'b0, 2'b00);
    test_sample("rs_3",      16'h0300, 16'd19200, 2'b10, 1'b0, 1'b0, 2'b10);
    test_sample("rs_half",   16'h0080, 16'd8534,  2'b00, 1'b0, 1'b1, 2'b00);
    test_sample("rs_max",    16'hFFFF, 16'd25501, 2'b10, 1'b0, 1'b0, 2'b10);
    test_sample("ob_below",  16'h0255, 16'd17917, 2'b00, 1'b0, 1'b1, 2'b00);
    test_sample("ob_edge",   16'h0256, 16'd17926, 2'b10, 1'b0, 1'b0, 2'b10);
    test_sample("os_edge",   16'h006E, 16'd7694,  2'b00, 1'b0, 1'b1, 2'b01);
    test_sample("os_below",  16'h006D, 16'd7645,  2'b01, 1'b0, 1'b0, 2'b01);
    test_sample("os_leave",  16'h0100, 16'd12800, 2'b00, 1'b1, 1'b0, 2'b00);
    test_overrun();
    test_reset_mid_div();
    test_sample("post_rst",  16'h0300, 16'd19200, 2'b10, 1'b0, 1'b0, 2'b10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
